twiddle_mul27: RTL and testbench

TWIDDLE_MUL27 -- requirements
Module: twiddle_mul27

---
 rtl/twiddle_mul27_pkg.sv | 17 +
 rtl/twiddle_rom27.sv | 50 +++++
 rtl/twiddle_mul27.sv | 172 +++++++++++++++++
 tb/tb_twiddle_mul27.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/twiddle_mul27_pkg.sv
// Shared constants and helpers for the radix-27 twiddle rotator.
// Twiddles are Q10 fixed point: 1.0 == TW_ONE, products are rounded back
// to sample scale by adding ROUND_BIAS and shifting right by TW_SHIFT.
package twiddle_mul27_pkg;

    localparam int N27        = 27;
    localparam int AW         = 5;     // width of index, stride and address
    localparam int TW_ONE     = 1024;
    localparam int TW_SHIFT   = 10;
    localparam int ROUND_BIAS = 512;

    // Reduce a 5-bit value (0..31) modulo 27 with a single conditional subtract.
    function automatic logic [AW-1:0] mod27(input logic [AW-1:0] v);
        return (v >= AW'(N27)) ? v - AW'(N27) : v;
    endfunction

endpackage

// File: rtl/twiddle_rom27.sv
// Combinational 27-entry twiddle table, W^n = exp(-j*2*pi*n/27) in Q10.
// Entries are floor(1024*cos) and floor(-1024*sin).
// Addresses 27..31 are never generated and return zero.
module twiddle_rom27
    import twiddle_mul27_pkg::*;
#(
    parameter int TWW = 18
) (
    input  logic [AW-1:0]         addr,
    output logic signed [TWW-1:0] tw_re,
    output logic signed [TWW-1:0] tw_im
);

    // Table lookup: one (re, im) pair per address.
    always_comb begin
        tw_re = '0;
        tw_im = '0;
        case (addr)
            5'd0:  begin tw_re = TWW'(1024);  tw_im = TWW'(0);     end
            5'd1:  begin tw_re = TWW'(996);   tw_im = TWW'(-237);  end
            5'd2:  begin tw_re = TWW'(915);   tw_im = TWW'(-460);  end
            5'd3:  begin tw_re = TWW'(784);   tw_im = TWW'(-659);  end
            5'd4:  begin tw_re = TWW'(611);   tw_im = TWW'(-822);  end
            5'd5:  begin tw_re = TWW'(405);   tw_im = TWW'(-941);  end
            5'd6:  begin tw_re = TWW'(177);   tw_im = TWW'(-1009); end
            5'd7:  begin tw_re = TWW'(-60);   tw_im = TWW'(-1023); end
            5'd8:  begin tw_re = TWW'(-294);  tw_im = TWW'(-981);  end
            5'd9:  begin tw_re = TWW'(-512);  tw_im = TWW'(-887);  end
            5'd10: begin tw_re = TWW'(-703);  tw_im = TWW'(-745);  end
            5'd11: begin tw_re = TWW'(-856);  tw_im = TWW'(-563);  end
            5'd12: begin tw_re = TWW'(-963);  tw_im = TWW'(-351);  end
            5'd13: begin tw_re = TWW'(-1018); tw_im = TWW'(-119);  end
            5'd14: begin tw_re = TWW'(-1018); tw_im = TWW'(118);   end
            5'd15: begin tw_re = TWW'(-963);  tw_im = TWW'(350);   end
            5'd16: begin tw_re = TWW'(-856);  tw_im = TWW'(562);   end
            5'd17: begin tw_re = TWW'(-703);  tw_im = TWW'(744);   end
            5'd18: begin tw_re = TWW'(-512);  tw_im = TWW'(886);   end
            5'd19: begin tw_re = TWW'(-294);  tw_im = TWW'(980);   end
            5'd20: begin tw_re = TWW'(-60);   tw_im = TWW'(1022);  end
            5'd21: begin tw_re = TWW'(177);   tw_im = TWW'(1008);  end
            5'd22: begin tw_re = TWW'(405);   tw_im = TWW'(940);   end
            5'd23: begin tw_re = TWW'(611);   tw_im = TWW'(821);   end
            5'd24: begin tw_re = TWW'(784);   tw_im = TWW'(658);   end
            5'd25: begin tw_re = TWW'(915);   tw_im = TWW'(459);   end
            5'd26: begin tw_re = TWW'(996);   tw_im = TWW'(236);   end
            default: begin tw_re = '0; tw_im = '0; end
        endcase
    end

endmodule

// File: rtl/twiddle_mul27.sv
// Streaming complex rotator: out = in * W^((idx*stride) mod 27).
// Three registered stages: twiddle lookup, four products, sum/round/limit.
// Build option TWIDDLE_MUL27_SAT_EN: clamp results to the DW range instead
// of keeping the low DW bits.
//
// Handshake: a beat moves on a port when valid && ready are both high at a
// rising clk edge. Valid never depends on ready. in_ready equals the shared
// stage-advance enable (!out_valid || out_ready); while low every stage
// holds, so samples are neither dropped nor repeated.
module twiddle_mul27
    import twiddle_mul27_pkg::*;
#(
    parameter int DW  = 16,
    parameter int TWW = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sof,
    input  logic [4:0]           in_stride,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic                 err_seq
);

    localparam int PW = DW + TWW;

`ifdef TWIDDLE_MUL27_SAT_EN
    localparam logic signed [PW:0] SAT_MAX = (PW+1)'((64'sd1 <<< (DW-1)) - 64'sd1);
    localparam logic signed [PW:0] SAT_MIN = -SAT_MAX - (PW+1)'(1);
`endif

    // Round-shift back to sample scale and fit into DW bits.
    function automatic logic signed [DW-1:0] round_limit(input logic signed [PW:0] v);
        logic signed [PW:0] sh;
        sh = v >>> TW_SHIFT;
`ifdef TWIDDLE_MUL27_SAT_EN
        if (sh > SAT_MAX)      return SAT_MAX[DW-1:0];
        else if (sh < SAT_MIN) return SAT_MIN[DW-1:0];
        else                   return sh[DW-1:0];
`else
        return sh[DW-1:0];
`endif
    endfunction

    logic          adv, accept;
    logic [AW-1:0] idx, stride, acc;
    logic [AW-1:0] cur_idx, cur_stride, cur_addr;
    logic [AW:0]   acc_sum;
    logic          seq_err;

    logic signed [TWW-1:0] rom_re, rom_im;

    logic                  s1_valid, s1_sof, s1_eof;
    logic signed [DW-1:0]  s1_re, s1_im;
    logic signed [TWW-1:0] s1_tw_re, s1_tw_im;

    logic                  s2_valid, s2_sof, s2_eof;
    logic signed [PW-1:0]  s2_ac, s2_bd, s2_ad, s2_bc;

    logic signed [PW:0]    re_full, im_full;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    // Index/stride/address seen by the sample on the input port; in_sof restarts the frame.
    always_comb begin
        cur_idx    = idx;
        cur_stride = stride;
        cur_addr   = acc;
        seq_err    = (idx == '0);
        if (in_sof) begin
            cur_idx    = '0;
            cur_stride = mod27(in_stride);
            cur_addr   = '0;
            seq_err    = (idx != '0);
        end
        acc_sum = {1'b0, cur_addr} + {1'b0, cur_stride};
    end

    // Frame tracking: advance idx and the address accumulator on each accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            stride  <= '0;
            acc     <= '0;
            err_seq <= 1'b0;
        end else if (accept) begin
            idx    <= (cur_idx == AW'(N27-1)) ? '0 : cur_idx + 1'b1;
            stride <= cur_stride;
            acc    <= AW'((acc_sum >= (AW+1)'(N27)) ? acc_sum - (AW+1)'(N27) : acc_sum);
            if (seq_err) err_seq <= 1'b1;
        end
    end

    twiddle_rom27 #(.TWW(TWW)) u_rom (
        .addr  (cur_addr),
        .tw_re (rom_re),
        .tw_im (rom_im)
    );

    // S1: register the sample, its twiddle and frame markers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_eof   <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_tw_re <= '0;
            s1_tw_im <= '0;
        end else if (adv) begin
            s1_valid <= accept;
            s1_sof   <= accept && (cur_idx == '0);
            s1_eof   <= accept && (cur_idx == AW'(N27-1));
            s1_re    <= in_re;
            s1_im    <= in_im;
            s1_tw_re <= rom_re;
            s1_tw_im <= rom_im;
        end
    end

    // S2: the four full-precision partial products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_eof   <= 1'b0;
            s2_ac    <= '0;
            s2_bd    <= '0;
            s2_ad    <= '0;
            s2_bc    <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_eof   <= s1_eof;
            s2_ac    <= PW'(s1_re) * PW'(s1_tw_re);
            s2_bd    <= PW'(s1_im) * PW'(s1_tw_im);
            s2_ad    <= PW'(s1_re) * PW'(s1_tw_im);
            s2_bc    <= PW'(s1_im) * PW'(s1_tw_re);
        end
    end

    assign re_full = (PW+1)'(s2_ac) - (PW+1)'(s2_bd) + (PW+1)'(ROUND_BIAS);
    assign im_full = (PW+1)'(s2_ad) + (PW+1)'(s2_bc) + (PW+1)'(ROUND_BIAS);

    // S3: output register with rounded, range-limited result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            out_sof   <= s2_sof;
            out_eof   <= s2_eof;
            out_re    <= round_limit(re_full);
            out_im    <= round_limit(im_full);
        end
    end

endmodule

// File: tb/tb_twiddle_mul27.sv
// Bench for twiddle_mul27: directed frames, expected samples queued at
// acceptance and checked by an independent output monitor.
module tb_twiddle_mul27;

    localparam int DW  = 16;
    localparam int TWW = 18;
    localparam int EW  = 2*DW + 2;
    localparam real PI = 3.14159265358979323846;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid, in_ready, in_sof;
    logic [4:0]           in_stride;
    logic signed [DW-1:0] in_re, in_im;
    logic                 out_valid, out_ready;
    logic signed [DW-1:0] out_re, out_im;
    logic                 out_sof, out_eof, err_seq;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int out_n      = 0;

    logic [EW-1:0] exp_q[$];
    int            lat_q[$];

    twiddle_mul27 #(.DW(DW), .TWW(TWW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_stride (in_stride),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .err_seq   (err_seq)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference twiddles from the definition W^n = exp(-j*2*pi*n/27), floored.
    function automatic int tw_re(int n);
        return int'($floor(1024.0 * $cos(2.0 * PI * n / 27.0) + 1.0e-6));
    endfunction

    function automatic int tw_im(int n);
        return int'($floor(-1024.0 * $sin(2.0 * PI * n / 27.0) + 1.0e-6));
    endfunction

    function automatic int fit(longint v);
`ifdef TWIDDLE_MUL27_SAT_EN
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
`else
        logic signed [DW-1:0] t;
        t = DW'(v);
        return int'(t);
`endif
    endfunction

    function automatic int rot_re(int a, int b, int c, int d);
        longint p;
        p = longint'(a) * c - longint'(b) * d;
        return fit((p + 512) >>> 10);
    endfunction

    function automatic int rot_im(int a, int b, int c, int d);
        longint p;
        p = longint'(a) * d + longint'(b) * c;
        return fit((p + 512) >>> 10);
    endfunction

    task automatic check(input string name, input longint act, input longint want);
        compared++;
        if (act != want) begin
            mismatched++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    // Driver: present one sample, wait (bounded) for acceptance, queue its expectation.
    task automatic send(input bit sof, input int stride, input int re, input int im,
                        input int ere, input int eim, input bit esof, input bit eeof,
                        input bit lat_chk);
        int n;
        in_valid  = 1'b1;
        in_sof    = sof;
        in_stride = 5'(stride);
        in_re     = DW'(re);
        in_im     = DW'(im);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: in_ready=%0b, want 1 within 200 cycles", in_ready);
        end else begin
            exp_q.push_back({DW'(ere), DW'(eim), esof, eeof});
            lat_q.push_back(lat_chk ? cyc : -1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // Monitor: every output transfer is popped from the queue and compared.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        int            l;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_output: got re=%0d im=%0d, want no output",
                         out_re, out_im);
            end else begin
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                compared++;
                if ({out_re, out_im, out_sof, out_eof} !== e) begin
                    mismatched++;
                    $display("FAIL out_sample #%0d: got re=%0d im=%0d sof=%0b eof=%0b, want re=%0d im=%0d sof=%0b eof=%0b",
                             out_n, out_re, out_im, out_sof, out_eof,
                             $signed(e[EW-1:DW+2]), $signed(e[DW+1:2]), e[1], e[0]);
                end
                if (l >= 0) begin
                    compared++;
                    if (cyc - l != 3) begin
                        mismatched++;
                        $display("FAIL latency #%0d: got %0d cycles, want 3", out_n, cyc - l);
                    end
                end
            end
            out_n++;
        end
    end

    // Watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog");
    end

    // Stimulus sequence.
    initial begin
        int a, b, ad, n;
        in_valid = 1'b0; in_sof = 1'b0; in_stride = '0; in_re = '0; in_im = '0;
        out_ready = 1'b1;
        rst_n = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_out_eof", out_eof, 0);
        check("rst_out_re", out_re, 0);
        check("rst_out_im", out_im, 0);
        check("rst_err_seq", err_seq, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Frame A: stride 0 is the identity rotation.
        for (int k = 0; k < 27; k++)
            send(k == 0, 0, k, -k, k, -k, k == 0, k == 26, 1'b1);

        // Frame B: stride 1 with the two worked examples at idx 3 and idx 9.
        for (int k = 0; k < 27; k++) begin
            if (k == 3)
`ifdef TWIDDLE_MUL27_SAT_EN
                send(1'b0, 1, -32768, -32768, -32768, -4000, 1'b0, 1'b0, 1'b1);
`else
                send(1'b0, 1, -32768, -32768, 19360, -4000, 1'b0, 1'b0, 1'b1);
`endif
            else if (k == 9)
                send(1'b0, 1, 1000, 0, -500, -866, 1'b0, 1'b0, 1'b1);
            else
                send(k == 0, 1, 1024, 0, tw_re(k), tw_im(k), k == 0, k == 26, 1'b1);
        end

        // Frame C: stride 29 acts as stride 2; output stalled for 5 cycles mid-frame.
        fork
            begin
                for (int k = 0; k < 27; k++) begin
                    ad = (2 * k) % 27;
                    send(k == 0, 29, 1024, 0, tw_re(ad), tw_im(ad), k == 0, k == 26, 1'b0);
                end
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("err_seq_clean", err_seq, 0);

        // Frame D: in_sof arrives at idx 5 and restarts the frame.
        for (int k = 0; k < 5; k++)
            send(k == 0, 0, 100 + k, -100 - k, 100 + k, -100 - k, k == 0, 1'b0, 1'b1);
        for (int k = 0; k < 27; k++)
            send(k == 0, 0, 200 + k, 50 - k, 200 + k, 50 - k, k == 0, k == 26, 1'b1);
        repeat (5) @(negedge clk);
        check("err_seq_set", err_seq, 1);
        @(posedge clk);
        #1;

        // Frame E: stride 7 with general data.
        for (int k = 0; k < 27; k++) begin
            a  = 300 * k - 4000;
            b  = 1234 - 200 * k;
            ad = (7 * k) % 27;
            send(k == 0, 7, a, b, rot_re(a, b, tw_re(ad), tw_im(ad)),
                 rot_im(a, b, tw_re(ad), tw_im(ad)), k == 0, k == 26, 1'b1);
        end
        check("err_seq_held", err_seq, 1);

        // Frame F: reset pulse with samples in flight.
        for (int k = 0; k < 10; k++)
            send(k == 0, 0, k, k, k, k, k == 0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_err_seq", err_seq, 0);
        check("midrst_out_sof", out_sof, 0);
        exp_q.delete();
        lat_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;

        // Frame G: clean frame after reset, stride 5.
        for (int k = 0; k < 27; k++) begin
            ad = (5 * k) % 27;
            send(k == 0, 5, 1024, 0, tw_re(ad), tw_im(ad), k == 0, k == 26, 1'b1);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", exp_q.size(), 0);
        check("final_err_seq", err_seq, 0);
        repeat (3) @(negedge clk);
        check("final_out_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
